eprisc_bus_arbiter: RTL and testbench
=====================================

Name: eprisc_bus_arbiter

Overview:
- Shares the single epRISC system memory bus between two requesters: the core (priority) and a DMA/debug master.
- Each requester has its own req/ack port. The arbiter serialises their transactions onto one memory port that may insert wait states.
- Fixed priority favours the core. A starvation counter guarantees the DMA master forward progress.
- A timeout aborts hung memory cycles, so the core pipeline never deadlocks on the bus.

Parameters:
pMaxConsec, 4, consecutive core grants allowed while DMA is waiting before DMA is forced to win (1..15)
pTimeout, 64, BUSY cycles without iMemReady before abort; 0 disables timeout (0..255)

Ports:
iClk  in  1  clock
iRst  in  1  synchronous, active-high reset
iCoreReq  in  1  core transaction request, held until oCoreAck
iCoreWrite  in  1  1 = write, 0 = read
iCoreAddr  in  32  core address
iCoreWData  in  32  core write data
oCoreRData  out  32  read data, valid in the oCoreAck cycle, held until next completion
oCoreAck  out  1  one-cycle completion pulse
iDmaReq, iDmaWrite, iDmaAddr, iDmaWData, oDmaRData, oDmaAck  as core port, DMA side
oMemEn  out  1  memory cycle active
oMemWrite  out  1  memory write strobe, qualified by oMemEn
oMemAddr  out  32  memory address
oMemWData  out  32  memory write data
iMemRData  in  32  memory read data, sampled when iMemReady=1
iMemReady  in  1  memory completes the current cycle
oErr  out  1  one-cycle pulse coincident with an ack when the transaction timed out
oOwner  out  1  owner of the current or last transaction: 0 = core, 1 = DMA

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including both RData registers.
  - Starvation and timeout counters 0.
  - A transaction in flight is dropped and no ack is issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - When any req is high, choose the winner and latch owner, addr, wdata and write. Go to BUSY next cycle.
  - With no req, stay in IDLE.
- Arbitration:
  - Core wins unless DMA is requesting and rStarve == pMaxConsec.
  - rStarve increments when core wins while iDmaReq=1.
  - rStarve clears when DMA wins or when iDmaReq=0 at arbitration.
  - rStarve saturates at pMaxConsec.
- BUSY:
  - oMemEn=1 and the latched values drive the memory port.
  - On iMemReady=1: latch iMemRData into the winner's RData (reads only; writes leave RData unchanged), then go to DONE.
  - rTimer counts BUSY cycles. If pTimeout != 0 and rTimer reaches pTimeout-1 without ready, set the abort flag, load RData with 32'hBADC0DE and go to DONE.
- DONE:
  - oMemEn=0.
  - Pulse the owner's ack for one cycle; oErr pulses with it if the transaction aborted.
  - Go to IDLE.
- Latency:
  - Minimum req-to-ack is 3 cycles (IDLE sample, BUSY with ready, DONE).
  - Each wait state adds 1 cycle.
  - Back-to-back transactions need 3 cycles each minimum.
- Requester rules:
  - Inputs must stay stable from req until ack.
  - A req still high in the cycle after ack is a new transaction.
  - A req dropped before ack is protocol misuse; the arbiter completes the latched transaction anyway.
- Ready sampling: iMemReady is ignored outside BUSY.
- Simultaneous events: both reqs high in IDLE are resolved by the arbitration rule; the loser keeps waiting.
- oOwner updates on the IDLE-to-BUSY transition.

Decomposition:
- Shared package/include holds:
  - state encodings `sArbIdle=0, `sArbBusy=1, `sArbDone=2;
  - owner constants `ArbOwnerCore=0, `ArbOwnerDma=1;
  - abort data constant 32'hBADC0DE.
- One sub-module, eprisc_arb_select: combinational winner choice plus the rStarve register update, with inputs (core req, DMA req, grant strobe) and pMaxConsec.
- The FSM, latches and timer stay in the top level.

Test Plan:
- Core read only, iMemReady high immediately, iMemRData=32'h12345678:
  - oCoreAck on cycle 3, oCoreRData=32'h12345678;
  - oMemEn high exactly 1 cycle; oErr=0.
- Core write addr 32'h100, data 32'hDEADBEEF, 2 wait states:
  - oMemWrite=1 and oMemAddr=32'h100 for 3 BUSY cycles;
  - ack on cycle 5; oCoreRData unchanged.
- Both reqs held continuously, pMaxConsec=4, zero wait:
  - grant order is C,C,C,C,D,C,C,C,C,D;
  - oOwner tracks this order.
- iMemReady never asserted, pTimeout=64:
  - ack plus oErr after 64 BUSY cycles;
  - oCoreRData=32'hBADC0DE;
  - next transaction completes normally.
- iRst asserted mid-BUSY:
  - next cycle all outputs 0 and state IDLE, with no ack;
  - request reissued after reset completes in 3 cycles.
- DMA only, read then write back-to-back:
  - two oDmaAck pulses 3 cycles apart;
  - core port outputs stay 0.

Source files
------------

// File: rtl/eprisc_bus_arbiter_pkg.sv
// Shared constants and types for the epRISC system-bus arbiter.
// State encodings, owner codes and the abort read-data pattern live here
// so the arbiter top and its selection sub-block agree on them.
package eprisc_bus_arbiter_pkg;

    // Arbiter FSM state encodings
    localparam logic [1:0] S_ARB_IDLE = 2'd0;
    localparam logic [1:0] S_ARB_BUSY = 2'd1;
    localparam logic [1:0] S_ARB_DONE = 2'd2;

    // Owner codes as reported on oOwner
    localparam logic ARB_OWNER_CORE = 1'b0;
    localparam logic ARB_OWNER_DMA  = 1'b1;

    // Read data returned to the owner when a memory cycle is aborted
    localparam logic [31:0] ARB_ABORT_DATA = 32'h0BAD_C0DE;

    // One requester's transaction as latched at arbitration
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    // Pick the winning requester's transaction fields
    function automatic bus_req_t pick_req(input logic     dma_sel,
                                          input bus_req_t core_req,
                                          input bus_req_t dma_req);
        return dma_sel ? dma_req : core_req;
    endfunction

endpackage

// File: rtl/eprisc_arb_select.sv
// Winner selection for the epRISC bus arbiter.
// Fixed priority to the core, overridden in favour of the DMA master once
// the core has won pMaxConsec arbitrations in a row while DMA was waiting.
module eprisc_arb_select
    import eprisc_bus_arbiter_pkg::*;
#(
    parameter int pMaxConsec = 4
) (
    input  logic iClk,
    input  logic iRst,
    input  logic core_req,
    input  logic dma_req,
    input  logic grant,
    output logic dma_wins
);

    localparam logic [3:0] MAX_CONSEC = 4'(pMaxConsec);

    // Consecutive core wins while DMA was requesting, saturating
    logic [3:0] starve;

    // DMA wins when it is alone, or when it has been starved long enough
    assign dma_wins = dma_req && (!core_req || (starve == MAX_CONSEC));

    // Starvation counter update, applied only on an actual grant
    always_ff @(posedge iClk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register in the design samples the same pre-edge values.
        if (iRst) begin
            starve <= '0;
        end else if (grant) begin
            if (dma_wins || !dma_req) begin
                starve <= '0;
            end else if (starve != MAX_CONSEC) begin
                starve <= starve + 4'd1;
            end
        end
    end

endmodule

// File: rtl/eprisc_bus_arbiter.sv
// Two-master arbiter for the single epRISC system memory bus.
// The core has priority; a starvation counter guarantees DMA progress and a
// BUSY-cycle timer aborts hung memory cycles so no requester deadlocks.
// Each transaction takes IDLE (arbitrate/latch), BUSY (memory cycle with
// optional wait states) and DONE (one-cycle ack to the owner).
module eprisc_bus_arbiter
    import eprisc_bus_arbiter_pkg::*;
#(
    parameter int pMaxConsec = 4,
    parameter int pTimeout   = 64
) (
    input  logic        iClk,
    input  logic        iRst,

    input  logic        iCoreReq,
    input  logic        iCoreWrite,
    input  logic [31:0] iCoreAddr,
    input  logic [31:0] iCoreWData,
    output logic [31:0] oCoreRData,
    output logic        oCoreAck,

    input  logic        iDmaReq,
    input  logic        iDmaWrite,
    input  logic [31:0] iDmaAddr,
    input  logic [31:0] iDmaWData,
    output logic [31:0] oDmaRData,
    output logic        oDmaAck,

    output logic        oMemEn,
    output logic        oMemWrite,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    input  logic [31:0] iMemRData,
    input  logic        iMemReady,

    output logic        oErr,
    output logic        oOwner
);

    localparam bit         TIMEOUT_EN = (pTimeout != 0);
    localparam logic [7:0] TIMER_LAST = TIMEOUT_EN ? 8'(pTimeout - 1) : 8'd0;

    logic [1:0]  state;
    logic        owner;
    bus_req_t    req_q;
    logic [7:0]  timer;

    logic [31:0] core_rdata;
    logic [31:0] dma_rdata;
    logic        core_ack;
    logic        dma_ack;
    logic        err;

    bus_req_t    core_req;
    bus_req_t    dma_req;
    logic        grant;
    logic        dma_wins;
    logic        busy;
    logic        timeout_hit;
    logic        complete;

    assign core_req = '{write: iCoreWrite, addr: iCoreAddr, wdata: iCoreWData};
    assign dma_req  = '{write: iDmaWrite,  addr: iDmaAddr,  wdata: iDmaWData};

    // Arbitration only happens from IDLE with at least one request pending
    assign grant = (state == S_ARB_IDLE) && (iCoreReq || iDmaReq);
    assign busy  = (state == S_ARB_BUSY);

    // Last permitted BUSY cycle passed without ready; ready always wins a tie
    assign timeout_hit = TIMEOUT_EN && busy && !iMemReady && (timer == TIMER_LAST);
    assign complete    = busy && (iMemReady || timeout_hit);

    eprisc_arb_select #(
        .pMaxConsec (pMaxConsec)
    ) u_select (
        .iClk     (iClk),
        .iRst     (iRst),
        .core_req (iCoreReq),
        .dma_req  (iDmaReq),
        .grant    (grant),
        .dma_wins (dma_wins)
    );

    // FSM sequencing, transaction latch and BUSY-cycle timer
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= S_ARB_IDLE;
            owner <= ARB_OWNER_CORE;
            req_q <= '0;
            timer <= '0;
        end else begin
            case (state)
                S_ARB_IDLE: begin
                    if (grant) begin
                        owner <= dma_wins ? ARB_OWNER_DMA : ARB_OWNER_CORE;
                        req_q <= pick_req(dma_wins, core_req, dma_req);
                        timer <= '0;
                        state <= S_ARB_BUSY;
                    end
                end
                S_ARB_BUSY: begin
                    if (complete) begin
                        state <= S_ARB_DONE;
                    end else if (timer != 8'hFF) begin
                        timer <= timer + 8'd1;
                    end
                end
                S_ARB_DONE: begin
                    state <= S_ARB_IDLE;
                end
                default: begin
                    state <= S_ARB_IDLE;
                end
            endcase
        end
    end

    // Completion: steer read data or the abort code to the owner, pulse ack/err
    always_ff @(posedge iClk) begin
        if (iRst) begin
            core_rdata <= '0;
            dma_rdata  <= '0;
            core_ack   <= 1'b0;
            dma_ack    <= 1'b0;
            err        <= 1'b0;
        end else begin
            core_ack <= complete && (owner == ARB_OWNER_CORE);
            dma_ack  <= complete && (owner == ARB_OWNER_DMA);
            err      <= timeout_hit;
            if (timeout_hit) begin
                if (owner == ARB_OWNER_DMA) begin
                    dma_rdata <= ARB_ABORT_DATA;
                end else begin
                    core_rdata <= ARB_ABORT_DATA;
                end
            end else if (complete && !req_q.write) begin
                if (owner == ARB_OWNER_DMA) begin
                    dma_rdata <= iMemRData;
                end else begin
                    core_rdata <= iMemRData;
                end
            end
        end
    end

    // Memory port: latched transaction during BUSY, quiet otherwise
    always_comb begin
        // NOTE: every output gets a default before the condition, so no path
        // leaves a value unassigned and no latch is inferred.
        oMemEn    = 1'b0;
        oMemWrite = 1'b0;
        oMemAddr  = '0;
        oMemWData = '0;
        if (busy) begin
            oMemEn    = 1'b1;
            oMemWrite = req_q.write;
            oMemAddr  = req_q.addr;
            oMemWData = req_q.wdata;
        end
    end

    assign oCoreRData = core_rdata;
    assign oDmaRData  = dma_rdata;
    assign oCoreAck   = core_ack;
    assign oDmaAck    = dma_ack;
    assign oErr       = err;
    assign oOwner     = owner;

endmodule

// File: tb/tb_eprisc_bus_arbiter.sv
// Self-checking bench for eprisc_bus_arbiter: directed vector table,
// hand-written multi-cycle sequences and a randomized run scored against
// a transaction-level model of the arbitration rules.
module tb_eprisc_bus_arbiter;

    localparam int MAX_CONSEC = 4;
    localparam int TIMEOUT    = 64;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iCoreReq, iCoreWrite, iDmaReq, iDmaWrite;
    logic [31:0] iCoreAddr, iCoreWData, iDmaAddr, iDmaWData;
    logic [31:0] oCoreRData, oDmaRData;
    logic        oCoreAck, oDmaAck;
    logic        oMemEn, oMemWrite;
    logic [31:0] oMemAddr, oMemWData;
    logic [31:0] iMemRData;
    logic        iMemReady;
    logic        oErr, oOwner;

    eprisc_bus_arbiter #(
        .pMaxConsec (MAX_CONSEC),
        .pTimeout   (TIMEOUT)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iCoreReq   (iCoreReq),
        .iCoreWrite (iCoreWrite),
        .iCoreAddr  (iCoreAddr),
        .iCoreWData (iCoreWData),
        .oCoreRData (oCoreRData),
        .oCoreAck   (oCoreAck),
        .iDmaReq    (iDmaReq),
        .iDmaWrite  (iDmaWrite),
        .iDmaAddr   (iDmaAddr),
        .iDmaWData  (iDmaWData),
        .oDmaRData  (oDmaRData),
        .oDmaAck    (oDmaAck),
        .oMemEn     (oMemEn),
        .oMemWrite  (oMemWrite),
        .oMemAddr   (oMemAddr),
        .oMemWData  (oMemWData),
        .iMemRData  (iMemRData),
        .iMemReady  (iMemReady),
        .oErr       (oErr),
        .oOwner     (oOwner)
    );

    always #5 iClk = ~iClk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory model: read data is a fixed hash of the address unless forced
    function automatic logic [31:0] mem_hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    bit          mem_hang      = 1'b0;
    bit          mem_force     = 1'b0;
    bit          mem_rand_wait = 1'b0;
    int          mem_wait      = 0;
    logic [31:0] mem_force_data = '0;
    int          busy_cnt      = 0;
    int          cur_wait      = 0;

    // Memory responder: ready after cur_wait wait states of an active cycle
    always @(negedge iClk) begin
        if (oMemEn) begin
            if (busy_cnt == 0)
                cur_wait = mem_rand_wait ? int'($urandom_range(0, 3)) : mem_wait;
            iMemReady = !mem_hang && (busy_cnt == cur_wait);
            iMemRData = mem_force ? mem_force_data : mem_hash(oMemAddr);
            busy_cnt++;
        end else begin
            iMemReady = 1'b0;
            iMemRData = 32'hFFFF_FFFF;
            busy_cnt  = 0;
        end
    end

    typedef struct {
        bit          dma;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        bit          hang;
        logic [31:0] mem_data;
        logic [31:0] exp_rdata;
        logic [31:0] exp_other;
        int          exp_lat;
        int          exp_en;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

    // One isolated transaction from an IDLE arbiter, checked end to end
    task automatic run_vec(input string tag, input vec_t v);
        int  n;
        int  en_cnt;
        bit  port_ok;
        bit  stray;
        bit  got_ack;
        @(negedge iClk);
        mem_wait = v.waits; mem_hang = v.hang; mem_force = 1'b1; mem_force_data = v.mem_data;
        if (v.dma) begin
            iDmaReq = 1'b1; iDmaWrite = v.wr; iDmaAddr = v.addr; iDmaWData = v.wdata;
        end else begin
            iCoreReq = 1'b1; iCoreWrite = v.wr; iCoreAddr = v.addr; iCoreWData = v.wdata;
        end
        n = 0; en_cnt = 0; port_ok = 1'b1; stray = 1'b0; got_ack = 1'b0;
        while (!got_ack && n < 200) begin
            @(negedge iClk);
            n++;
            if (oMemEn) begin
                en_cnt++;
                if (oMemAddr !== v.addr || oMemWrite !== v.wr || (v.wr && oMemWData !== v.wdata))
                    port_ok = 1'b0;
            end
            if (v.dma ? oCoreAck : oDmaAck) stray = 1'b1;
            if (v.dma ? oDmaAck : oCoreAck) got_ack = 1'b1;
        end
        check({tag, "_ack_seen"}, got_ack, 1'b1);
        check({tag, "_latency"}, n + 1, v.exp_lat);
        check({tag, "_busy_cycles"}, en_cnt, v.exp_en);
        check({tag, "_mem_port"}, port_ok, 1'b1);
        check({tag, "_rdata"}, v.dma ? oDmaRData : oCoreRData, v.exp_rdata);
        check({tag, "_other_rdata"}, v.dma ? oCoreRData : oDmaRData, v.exp_other);
        check({tag, "_err"}, oErr, v.exp_err);
        check({tag, "_owner"}, oOwner, v.dma);
        check({tag, "_no_stray_ack"}, stray, 1'b0);
        iCoreReq = 1'b0; iDmaReq = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iRst = 1'b1; iCoreReq = 1'b0; iDmaReq = 1'b0;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
    endtask

    task automatic new_core_txn();
        iCoreReq = 1'b1; iCoreWrite = 1'($urandom_range(0, 1));
        iCoreAddr = $urandom & 32'h0000_FFFC; iCoreWData = $urandom;
    endtask

    task automatic new_dma_txn();
        iDmaReq = 1'b1; iDmaWrite = 1'($urandom_range(0, 1));
        iDmaAddr = $urandom & 32'h0000_FFFC; iDmaWData = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    int          t, t1, t2, grants, consec, core_age, dma_age;
    bit          prev_en, exp_d, core_stray, inflight_dma;
    logic [31:0] exp_core_rd, exp_dma_rd;
    vec_t        v_after;

    initial begin
        iRst = 1'b1;
        iCoreReq = 0; iCoreWrite = 0; iCoreAddr = 0; iCoreWData = 0;
        iDmaReq = 0; iDmaWrite = 0; iDmaAddr = 0; iDmaWData = 0;

        //              dma wr addr       wdata         wt hg mem_data      exp_rdata     exp_other  lat en err
        vecs[0] = '{0, 0, 32'h40,  32'h0,        0, 0, 32'h12345678, 32'h12345678, 32'h0,        3,  1, 0};
        vecs[1] = '{0, 1, 32'h100, 32'hDEADBEEF, 2, 0, 32'h77777777, 32'h12345678, 32'h0,        5,  3, 0};
        vecs[2] = '{0, 0, 32'h200, 32'h0,        0, 1, 32'h0,        32'h0BADC0DE, 32'h0,        66, 64, 1};
        vecs[3] = '{0, 0, 32'h204, 32'h0,        0, 0, 32'hCAFE0001, 32'hCAFE0001, 32'h0,        3,  1, 0};
        vecs[4] = '{1, 0, 32'h300, 32'h0,        1, 0, 32'h0F0F1234, 32'h0F0F1234, 32'hCAFE0001, 4,  2, 0};
        vecs[5] = '{1, 1, 32'h304, 32'h11112222, 0, 0, 32'h99999999, 32'h0F0F1234, 32'hCAFE0001, 3,  1, 0};
        vecs[6] = '{1, 0, 32'h308, 32'h0,        0, 1, 32'h0,        32'h0BADC0DE, 32'hCAFE0001, 66, 64, 1};
        vecs[7] = '{1, 1, 32'h30C, 32'h33334444, 3, 0, 32'h99999999, 32'h0BADC0DE, 32'hCAFE0001, 6,  4, 0};

        // Reset state
        repeat (2) @(negedge iClk);
        check("rst_strobes", {26'b0, oCoreAck, oDmaAck, oErr, oOwner, oMemEn, oMemWrite}, 32'h0);
        check("rst_mem_addr", oMemAddr, 32'h0);
        check("rst_mem_wdata", oMemWData, 32'h0);
        check("rst_core_rdata", oCoreRData, 32'h0);
        check("rst_dma_rdata", oDmaRData, 32'h0);
        iRst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 8; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Both requesters held: starvation limit forces every fifth grant to DMA
        @(negedge iClk);
        mem_force = 1'b0; mem_wait = 0; mem_hang = 1'b0;
        iCoreReq = 1'b1; iCoreWrite = 1'b0; iCoreAddr = 32'h500;
        iDmaReq  = 1'b1; iDmaWrite  = 1'b0; iDmaAddr  = 32'h600;
        grants = 0; t = 0; prev_en = 1'b0;
        while (grants < 10 && t < 100) begin
            @(negedge iClk);
            t++;
            if (oMemEn && !prev_en) begin
                exp_d = ((grants % (MAX_CONSEC + 1)) == MAX_CONSEC);
                check($sformatf("prio_owner_%0d", grants), oOwner, exp_d);
                check($sformatf("prio_addr_%0d", grants), oMemAddr, exp_d ? 32'h600 : 32'h500);
                grants++;
            end
            prev_en = oMemEn;
        end
        check("prio_grant_count", grants, 10);
        iCoreReq = 1'b0; iDmaReq = 1'b0;
        repeat (4) @(negedge iClk);

        // Reset in the middle of a hung BUSY cycle
        @(negedge iClk);
        mem_hang = 1'b1; mem_force = 1'b1; mem_force_data = 32'h0;
        iCoreReq = 1'b1; iCoreWrite = 1'b0; iCoreAddr = 32'h700;
        repeat (3) @(negedge iClk);
        check("midrst_busy_before", oMemEn, 1'b1);
        iRst = 1'b1; iCoreReq = 1'b0;
        @(negedge iClk);
        check("midrst_strobes", {26'b0, oCoreAck, oDmaAck, oErr, oOwner, oMemEn, oMemWrite}, 32'h0);
        check("midrst_mem_addr", oMemAddr, 32'h0);
        check("midrst_core_rdata", oCoreRData, 32'h0);
        check("midrst_dma_rdata", oDmaRData, 32'h0);
        @(negedge iClk);
        check("midrst_no_ack", {29'b0, oCoreAck, oDmaAck, oErr}, 32'h0);
        iRst = 1'b0; mem_hang = 1'b0;
        v_after = '{0, 0, 32'h704, 32'h0, 0, 0, 32'h76543210, 32'h76543210, 32'h0, 3, 1, 0};
        run_vec("after_rst", v_after);

        // DMA-only read then write, request held through the first ack
        do_reset();
        @(negedge iClk);
        mem_force = 1'b1; mem_force_data = 32'hA1A2A3A4; mem_wait = 0; mem_hang = 1'b0;
        iDmaReq = 1'b1; iDmaWrite = 1'b0; iDmaAddr = 32'h800; iDmaWData = 32'h0;
        core_stray = 1'b0; t = 0; t1 = -1; t2 = -1;
        while (t2 < 0 && t < 50) begin
            @(negedge iClk);
            t++;
            if (oCoreAck || oCoreRData !== 32'h0) core_stray = 1'b1;
            if (oMemEn && oMemWrite) check("dma_b2b_wdata", oMemWData, 32'h5555AAAA);
            if (oDmaAck) begin
                if (t1 < 0) begin
                    t1 = t;
                    check("dma_b2b_read_data", oDmaRData, 32'hA1A2A3A4);
                    iDmaWrite = 1'b1; iDmaAddr = 32'h804; iDmaWData = 32'h5555AAAA;
                end else begin
                    t2 = t;
                    check("dma_b2b_write_keeps_rdata", oDmaRData, 32'hA1A2A3A4);
                    iDmaReq = 1'b0;
                end
            end
        end
        check("dma_b2b_first_latency", t1 + 1, 3);
        check("dma_b2b_spacing", t2 - t1, 3);
        check("dma_b2b_core_quiet", core_stray, 1'b0);

        // Randomized traffic scored against a transaction-level model
        do_reset();
        mem_force = 1'b0; mem_rand_wait = 1'b1; mem_hang = 1'b0;
        consec = 0; exp_core_rd = '0; exp_dma_rd = '0; inflight_dma = 1'b0;
        prev_en = 1'b0; core_age = 0; dma_age = 0;
        for (int cyc = 0; cyc < 3300; cyc++) begin
            @(negedge iClk);
            if (oMemEn && !prev_en) begin
                exp_d = iDmaReq && (!iCoreReq || consec == MAX_CONSEC);
                check("rand_owner", oOwner, exp_d);
                check("rand_addr", oMemAddr, exp_d ? iDmaAddr : iCoreAddr);
                check("rand_write", oMemWrite, exp_d ? iDmaWrite : iCoreWrite);
                if ((exp_d ? iDmaWrite : iCoreWrite) == 1'b1)
                    check("rand_wdata", oMemWData, exp_d ? iDmaWData : iCoreWData);
                if (!exp_d && iDmaReq)
                    consec = (consec < MAX_CONSEC) ? consec + 1 : MAX_CONSEC;
                else
                    consec = 0;
                inflight_dma = exp_d;
            end
            prev_en = oMemEn;
            if (oCoreAck || oDmaAck) begin
                if (oCoreAck && !iCoreWrite) exp_core_rd = mem_hash(iCoreAddr);
                if (oDmaAck && !iDmaWrite) exp_dma_rd = mem_hash(iDmaAddr);
                check("rand_ack_port", {30'b0, oDmaAck, oCoreAck}, inflight_dma ? 32'd2 : 32'd1);
                check("rand_err", oErr, 1'b0);
                check("rand_core_rdata", oCoreRData, exp_core_rd);
                check("rand_dma_rdata", oDmaRData, exp_dma_rd);
                if (oCoreAck) begin
                    core_age = 0;
                    if (cyc < 3000 && $urandom_range(0, 1) == 1) new_core_txn();
                    else iCoreReq = 1'b0;
                end
                if (oDmaAck) begin
                    dma_age = 0;
                    if (cyc < 3000 && $urandom_range(0, 1) == 1) new_dma_txn();
                    else iDmaReq = 1'b0;
                end
            end
            if (cyc < 3000) begin
                if (!iCoreReq && $urandom_range(0, 2) == 0) new_core_txn();
                if (!iDmaReq && $urandom_range(0, 2) == 0) new_dma_txn();
            end
            if (iCoreReq) core_age++;
            if (iDmaReq) dma_age++;
            if (core_age > 200 || dma_age > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rand_progress: got wait core=%0d dma=%0d expected ack within 200 cycles",
                         core_age, dma_age);
                break;
            end
        end
        check("rand_drained", {30'b0, iCoreReq, iDmaReq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
